// File: rtl/candidate_encoder_if.sv
// Handshake bundle between the index counter, the candidate encoder and the
// MD5 message-block builder. The encoder sits on the slave side; whatever
// feeds indices and drains strings uses the master side.
interface candidate_encoder_if #(
  parameter int CHARS = 7
) ();
  logic               in_valid;
  logic [29:0]        in_index;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [CHARS*8-1:0] out_word;
  logic [29:0]        out_index;
  logic               out_overflow;
  logic               busy;

  modport master (
    output in_valid, in_index, out_ready,
    input  in_ready, out_valid, out_word, out_index, out_overflow, busy
  );

  modport slave (
    input  in_valid, in_index, out_ready,
    output in_ready, out_valid, out_word, out_index, out_overflow, busy
  );
endinterface

// File: rtl/candidate_encoder.sv
// Candidate encoder: turns a 30-bit brute-force index into a fixed-length
// lowercase base-BASE string, one digit per clock, least significant digit
// first. The first (most significant) character lands in out_word[7:0] so the
// MD5 block builder can stream bytes in memory order.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for an index, in_ready high
// CONVERT | peeling one base-BASE digit per cycle into out_word
// HOLD    | result presented with out_valid, waiting for out_ready
module candidate_encoder #(
  parameter int         CHARS      = 7,
  parameter int         BASE       = 26,
  parameter logic [7:0] FIRST_CHAR = 8'h61
) (
  input  logic                CLK,
  input  logic                reset,
  candidate_encoder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

  localparam int              CW     = (CHARS > 1) ? $clog2(CHARS) : 1;
  localparam logic [CW-1:0]   LAST   = CW'(CHARS - 1);
  localparam logic [29:0]     BASE_W = 30'(BASE);

  state_t             state, state_nxt;
  logic [29:0]        rem;
  logic [29:0]        rem_div;
  logic [29:0]        rem_mod;
  logic [CW-1:0]      digit;
  logic [CHARS*8-1:0] word;
  logic [29:0]        index;
  logic               overflow;
  logic               ready;
  logic               valid;
  logic               accept;
  logic               release_out;
  logic               last_digit;

  // Division by a constant radix folds into combinational logic; only one
  // divider exists per instance, shared across all digit steps.
  assign rem_div     = rem / BASE_W;
  assign rem_mod     = rem % BASE_W;
  assign accept      = bus.in_valid & ready;
  assign release_out = bus.out_ready & valid;
  assign last_digit  = (digit == LAST);

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)      state_nxt = CONVERT;
      CONVERT: if (last_digit)  state_nxt = HOLD;
      HOLD:    if (release_out) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Registered handshake flags, derived from where the FSM is heading.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ready <= 1'b1;
      valid <= 1'b0;
    end else begin
      ready <= (state_nxt == IDLE);
      valid <= (state_nxt == HOLD);
    end
  end

  // Datapath: latch the index, then emit one character per CONVERT cycle
  // from the right-hand end of the string towards byte 0.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rem      <= '0;
      digit    <= '0;
      word     <= '0;
      index    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rem   <= bus.in_index;
            index <= bus.in_index;
            digit <= '0;
          end
        end
        CONVERT: begin
          word[int'(LAST - digit) * 8 +: 8] <= 8'(30'(FIRST_CHAR) + rem_mod);
          rem   <= rem_div;
          digit <= digit + CW'(1);
          if (last_digit) overflow <= (rem_div != '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = ready;
  assign bus.out_valid    = valid;
  assign bus.out_word     = word;
  assign bus.out_index    = index;
  assign bus.out_overflow = overflow;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_candidate_encoder.sv
// Bench for candidate_encoder: scoreboard of expected strings pushed at
// accept time and popped when out_valid appears, plus a CHARS=6 instance for
// the overflow boundary.
module tb_candidate_encoder;

  typedef struct {
    logic [29:0] idx;
    logic [55:0] word;
    logic        ovf;
  } exp_t;

  logic CLK = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [55:0] last_word;
  logic        last_ovf;

  always #5 CLK = ~CLK;

  candidate_encoder_if #(.CHARS(7)) b7 ();
  candidate_encoder_if #(.CHARS(6)) b6 ();

  candidate_encoder #(.CHARS(7)) dut  (.CLK(CLK), .reset(reset), .bus(b7));
  candidate_encoder #(.CHARS(6)) dut6 (.CLK(CLK), .reset(reset), .bus(b6));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [29:0] idx);
    exp_t e;
    logic [29:0] r;
    r      = idx;
    e.idx  = idx;
    e.word = '0;
    for (int k = 0; k < 7; k++) begin
      e.word[8*(6-k) +: 8] = 8'h61 + 8'(r % 30'd26);
      r = r / 30'd26;
    end
    e.ovf = (r != 0);
    return e;
  endfunction

  // Called at a negedge; offers idx once the encoder is ready.
  task automatic send(input logic [29:0] idx);
    int n;
    n = 0;
    while (!b7.in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check_val("send_ready", b7.in_ready, 1);
    b7.in_valid = 1'b1;
    b7.in_index = idx;
    @(posedge CLK);
    @(negedge CLK);
    b7.in_valid = 1'b0;
    b7.in_index = 30'($urandom);
    sb.push_back(model(idx));
    check_val("busy_after_accept", b7.busy, 1);
    check_val("in_ready_after_accept", b7.in_ready, 0);
  endtask

  // Called at the negedge right after the accept edge. Holds off out_ready
  // for 'hold' cycles (pulsing in_valid meanwhile) and then completes it.
  task automatic recv(input int hold);
    int   n;
    logic rdy_low;
    logic stable;
    exp_t e;
    n       = 0;
    rdy_low = 1'b1;
    stable  = 1'b1;
    while (!b7.out_valid && n < 50) begin
      if (b7.in_ready) rdy_low = 1'b0;
      @(negedge CLK);
      n++;
    end
    check_val("latency", n, 7);
    check_val("in_ready_low_convert", rdy_low, 1);
    check_val("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val("word", b7.out_word, e.word);
      check_val("index", b7.out_index, e.idx);
      check_val("overflow", b7.out_overflow, e.ovf);
      check_val("in_ready_hold", b7.in_ready, 0);
      last_word = b7.out_word;
      last_ovf  = b7.out_overflow;
      if (hold > 0) begin
        b7.out_ready = 1'b0;
        for (int c = 0; c < hold; c++) begin
          b7.in_valid = (c % 2 == 0);
          b7.in_index = 30'd5;
          @(negedge CLK);
          if (b7.out_valid !== 1'b1 || b7.out_word !== e.word ||
              b7.out_index !== e.idx || b7.in_ready !== 1'b0)
            stable = 1'b0;
        end
        b7.in_valid = 1'b0;
        check_val("hold_stable", stable, 1);
      end
    end
    b7.out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    b7.out_ready = 1'b0;
    check_val("valid_drop", b7.out_valid, 0);
    check_val("ready_rise", b7.in_ready, 1);
    check_val("busy_drop", b7.busy, 0);
  endtask

  task automatic run6(input logic [29:0] idx, input logic [47:0] exp_word, input logic exp_ovf);
    int n;
    n = 0;
    b6.in_valid = 1'b1;
    b6.in_index = idx;
    @(posedge CLK);
    @(negedge CLK);
    b6.in_valid = 1'b0;
    while (!b6.out_valid && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check_val("c6_latency", n, 6);
    check_val("c6_word", b6.out_word, exp_word);
    check_val("c6_overflow", b6.out_overflow, exp_ovf);
    check_val("c6_index", b6.out_index, idx);
    b6.out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    b6.out_ready = 1'b0;
    check_val("c6_valid_drop", b6.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    b7.in_valid  = 1'b0;
    b7.in_index  = '0;
    b7.out_ready = 1'b0;
    b6.in_valid  = 1'b0;
    b6.in_index  = '0;
    b6.out_ready = 1'b0;
    reset        = 1'b1;
    repeat (3) @(negedge CLK);
    check_val("rst_in_ready", b7.in_ready, 1);
    check_val("rst_out_valid", b7.out_valid, 0);
    check_val("rst_busy", b7.busy, 0);
    check_val("rst_word", b7.out_word, 0);
    check_val("rst_index", b7.out_index, 0);
    check_val("rst_overflow", b7.out_overflow, 0);
    reset = 1'b0;
    @(negedge CLK);

    send(30'd0);
    recv(0);
    check_val("idx0_const", last_word, 56'h61616161616161);

    // Back-to-back: in_valid stays high across the first conversion.
    b7.in_valid = 1'b1;
    b7.in_index = 30'd1;
    @(posedge CLK);
    @(negedge CLK);
    b7.in_index = 30'd26;
    sb.push_back(model(30'd1));
    recv(0);
    check_val("b2b_first_const", last_word, 56'h62616161616161);
    @(posedge CLK);
    @(negedge CLK);
    b7.in_valid = 1'b0;
    sb.push_back(model(30'd26));
    recv(0);
    check_val("b2b_second_const", last_word, 56'h61626161616161);

    send(30'h3FFFFFFF);
    recv(20);
    check_val("max_const", last_word, 56'h6c6d6a726a6d64);
    check_val("max_ovf_const", last_ovf, 0);

    // Reset during the third CONVERT cycle discards the partial result.
    send(30'd12345);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    #1;
    check_val("midrst_out_valid", b7.out_valid, 0);
    check_val("midrst_in_ready", b7.in_ready, 1);
    check_val("midrst_busy", b7.busy, 0);
    check_val("midrst_word", b7.out_word, 0);
    void'(sb.pop_front());
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    send(30'd0);
    recv(0);
    check_val("post_rst_const", last_word, 56'h61616161616161);

    for (int t = 0; t < 6; t++) begin
      send(30'($urandom));
      recv(int'($urandom_range(0, 3)));
    end

    run6(30'd308915776, 48'h616161616161, 1'b1);
    run6(30'd308915775, 48'h7a7a7a7a7a7a, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/candidate_encoder.md
Name: candidate_encoder

Overview:
- Downstream stage of the brute-force index counter.
- Takes the 30-bit candidate index and converts it iteratively to a fixed-length lowercase base-26 password string. Conversion uses one digit per clock.
- The string is presented byte-ordered for the MD5 message-block builder that follows, with a valid/ready handshake.
- Sequential divide-by-BASE keeps logic small so many instances fit beside the MD5 cores.

Parameters:
- CHARS, 7, number of output characters; 26^7 > 2^30, so every 30-bit index fits.
- BASE, 26, radix (alphabet size).
- FIRST_CHAR, 8'h61, ASCII code of digit 0 ('a').

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_index is valid.
- in_index  in  30  candidate index from the counter.
- in_ready  out  1  block can accept an index (registered).
- out_valid  out  1  out_word/out_index/out_overflow are valid.
- out_ready  in  1  downstream accepts output.
- out_word  out  CHARS*8  candidate string; first (most significant) character in bits [7:0].
- out_index  out  30  index that produced out_word.
- out_overflow  out  1  index >= BASE^CHARS; string holds the low CHARS digits only.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values (async, immediate): state=IDLE, in_ready=1, out_valid=0, out_word=0, out_index=0, out_overflow=0, busy=0, internal remainder/digit counter=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready: latch rem<=in_index and out_index<=in_index; clear digit counter i<=0; go CONVERT; in_ready<=0.
  - CONVERT: each cycle writes the byte at position CHARS-1-i <= FIRST_CHAR + (rem % BASE), then rem<=rem/BASE and i<=i+1. When i==CHARS-1 the last byte is written, out_overflow<=(rem/BASE != 0), out_valid<=1, go HOLD.
  - HOLD: out_valid=1; outputs stable while out_ready=0. On out_ready: out_valid<=0, in_ready<=1, go IDLE.
- Latency: accept at edge k → out_valid high after edge k+CHARS (7 cycles at default).
- Throughput: one index per CHARS+2 cycles minimum; no overlap of accept and output.
- Arithmetic: rem is 30 bits; % and / by the constant BASE are combinational within one cycle; digit < BASE always.
- in_valid while in_ready=0 is ignored; in_index is not sampled.
- out_ready while out_valid=0 has no effect.
- out_word bytes not yet written during CONVERT hold stale values. Consumers use out_word only when out_valid=1.
- Reset asserted mid-CONVERT or in HOLD: immediate return to reset values; the partial conversion is discarded.
- Index wrap: no special case; index 0 is valid and produces all FIRST_CHAR.

Test Plan:
- Index 0, out_ready=1 → 7 cycles after accept: out_valid=1, out_word=56'h61616161616161 ("aaaaaaa"), out_overflow=0, out_index=0.
- Index 1 then index 26, back-to-back in_valid → first out_word=56'h62616161616161 ("aaaaaab"). Second is accepted only after the first handshake and gives out_word=56'h61626161616161 ("aaaaaba"). in_ready=0 throughout CONVERT/HOLD.
- Index 30'h3FFFFFFF → out_word=56'h6c6d6a726a6d64 ("dmjrjml"), out_overflow=0.
- Backpressure: out_ready=0 for 20 cycles after out_valid → out_valid, out_word and out_index held constant. in_valid pulses in this window are ignored. out_ready=1 → out_valid drops next edge, in_ready rises.
- Reset asserted on CONVERT cycle 3 with index 12345 → out_valid=0, in_ready=1, busy=0 immediately. Next accepted index 0 gives "aaaaaaa" with no residue.
- Parameter build CHARS=6, index 308915776 (26^6) → out_word=48'h616161616161, out_overflow=1.
